uarc_send_receiver: RTL and testbench
=====================================

// Module: uarc_send_receiver
// PURPOSE
//  Receiver-side front end for UARC "send" traffic, directly upstream of core0.
//  Performs a 4-phase handshake with every incoming bus and arbitrates among pending sends.
//  Queues accepted messages (data, bus index, self permission, self address) in a FIFO.
//  core0 drains the queue through a valid/ready port when it takes a send interrupt.
// PARAMETERS
//  WORD_MAG        5  log2 of the word width; WORD_WIDTH = 1 << WORD_MAG
//  TOTAL_BUSES     1  number of incoming UARC buses, 1..WORD_WIDTH*UARC_SETS
//  FIFO_DEPTH_MAG  2  log2 of FIFO depth; DEPTH = 1 << FIFO_DEPTH_MAG entries
// PORTS
//  clk                        in   1                     clock; all state updates on posedge
//  reset                      in   1                     asynchronous, active-low reset
//  bus_enables                in   TOTAL_BUSES           per-bus accept mask from core0 (1 = accept)
//  flush                      in   1                     synchronous clear of queued entries (kill)
//  receiver_sends             in   TOTAL_BUSES           per-bus send request, held until acked
//  receiver_send_acks         out  TOTAL_BUSES           per-bus ack, level, 4-phase
//  receiver_datas             in   TOTAL_BUSES*WORD_WIDTH   per-bus payload
//  receiver_self_permissions  in   TOTAL_BUSES*WORD_WIDTH   per-bus sender permission
//  receiver_self_addresses    in   TOTAL_BUSES*WORD_WIDTH   per-bus sender address
//  out_valid                  out  1                     head entry present
//  out_ready                  in   1                     core0 consumes the head entry this cycle
//  out_data                   out  WORD_WIDTH            head payload
//  out_bus                    out  WORD_WIDTH            head bus index, zero-extended
//  out_permission             out  WORD_WIDTH            head self permission
//  out_address                out  WORD_WIDTH            head self address
//  out_count                  out  FIFO_DEPTH_MAG+1      number of entries queued
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty; rd/wr pointers 0; all ack bits 0.
//   Outputs: out_valid=0, out_count=0, out_data/bus/permission/address=0.
//  Per-bus ack state: ack[i] is a register driven straight out on receiver_send_acks[i].
//  Eligible bus i: receiver_sends[i]=1, bus_enables[i]=1 and ack[i]=0.
//  Arbitration: fixed priority; the lowest eligible index wins; at most one capture per cycle.
//  Capture: at a posedge where a winner exists and count<DEPTH.
//   Write {data, index, permission, address} of the winner at wr_ptr.
//   Set ack[winner]. No capture when full; requests stay pending and ack stays 0.
//  Ack release: ack[i] clears at the first posedge where receiver_sends[i]=0.
//   Bus i is not re-arbitrated until then, so no duplicates within a handshake.
//  Latency: send seen in cycle N -> ack[i]=1 and the entry is visible in cycle N+1.
//   If the FIFO was empty, out_valid=1 in N+1.
//  Dequeue: out_valid & out_ready at a posedge advances rd_ptr.
//   out_ready while empty is ignored.
//  Simultaneous capture and dequeue: count unchanged; both pointers advance.
//   Capture is blocked when count==DEPTH even if a dequeue occurs the same cycle (no bypass).
//  Pointers are FIFO_DEPTH_MAG bits and wrap modulo DEPTH.
//   out_count = entries held, 0..DEPTH. Full: count==DEPTH. Empty: count==0.
//  Out fields are driven combinationally from the head entry; they read 0 when empty.
//  flush=1 at a posedge: count:=0 and pointers:=0; capture and dequeue are suppressed.
//   ack bits are unaffected and still release on send deassertion.
//  bus_enables only gates new captures; queued entries and held acks are unaffected.
//  Reset mid-handshake: acks drop; a sender still asserting send is captured again after reset.
//   This duplicate is permitted.
// TESTING
//  1 Reset: drive reset=0 with sends=all 1 -> acks=0, out_valid=0, out_count=0.
//    Release reset -> bus 0 captured next edge.
//  2 Single send: TOTAL_BUSES=4; bus2 sends data 0xDEADBEEF from cycle N.
//    -> ack[2]=1 and out_valid=1, out_bus=2, out_data=0xDEADBEEF in N+1.
//    Drop send -> ack[2]=0 next cycle.
//  3 Contention: buses 1 and 3 send in the same cycle -> bus1 acked in N+1, bus3 in N+2.
//    FIFO order is 1 then 3.
//  4 Full: DEPTH=4, out_ready=0, 5 buses send -> 4 acks, out_count=4, 5th ack stays 0.
//    A single dequeue -> 5th captured the following edge.
//  5 Mask/flush: bus_enables[0]=0 while bus0 sends -> no ack.
//    flush with 3 queued -> out_count=0 next cycle, held acks remain until sends drop.
//  6 Streaming: out_ready=1 with a new sender each cycle -> out_count stays 1.
//    Entries emerge in order and pointers wrap past DEPTH without loss.

Source files
------------

// File: rtl/uarc_send_receiver.sv
// Receiver-side front end for UARC send traffic: 4-phase ack per bus, fixed-priority
// arbitration of pending sends, and a FIFO of accepted messages drained by core0.
module uarc_send_receiver #(
   parameter  int WORD_MAG       = 5,
   parameter  int TOTAL_BUSES    = 1,
   parameter  int FIFO_DEPTH_MAG = 2,
   localparam int WORD_WIDTH     = 1 << WORD_MAG,
   localparam int DEPTH          = 1 << FIFO_DEPTH_MAG
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [TOTAL_BUSES-1:0]            bus_enables,
   input  logic                              flush,
   input  logic [TOTAL_BUSES-1:0]            receiver_sends,
   output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
   input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
   input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_self_permissions,
   input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_self_addresses,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WORD_WIDTH-1:0]             out_data,
   output logic [WORD_WIDTH-1:0]             out_bus,
   output logic [WORD_WIDTH-1:0]             out_permission,
   output logic [WORD_WIDTH-1:0]             out_address,
   output logic [FIFO_DEPTH_MAG:0]           out_count
);

   localparam int PTR_W = FIFO_DEPTH_MAG;
   localparam int CNT_W = FIFO_DEPTH_MAG + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [TOTAL_BUSES-1:0] r_ack;
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;

   logic [WORD_WIDTH-1:0]  r_mem_data [DEPTH];
   logic [WORD_WIDTH-1:0]  r_mem_bus  [DEPTH];
   logic [WORD_WIDTH-1:0]  r_mem_perm [DEPTH];
   logic [WORD_WIDTH-1:0]  r_mem_addr [DEPTH];

   logic [TOTAL_BUSES-1:0] w_elig;
   logic [TOTAL_BUSES-1:0] w_grant;
   logic                   w_found;
   logic [WORD_WIDTH-1:0]  w_win_idx;
   logic [WORD_WIDTH-1:0]  w_win_data;
   logic [WORD_WIDTH-1:0]  w_win_perm;
   logic [WORD_WIDTH-1:0]  w_win_addr;
   logic                   w_capture;
   logic                   w_dequeue;
   logic                   w_valid;

   // A bus already holding an ack is excluded so one handshake yields one entry.
   assign w_elig = receiver_sends & bus_enables & ~r_ack;

   always_comb begin
      w_found    = 1'b0;
      w_grant    = '0;
      w_win_idx  = '0;
      w_win_data = '0;
      w_win_perm = '0;
      w_win_addr = '0;
      for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_found    = 1'b1;
            w_grant    = '0;
            w_grant[i] = 1'b1;
            w_win_idx  = WORD_WIDTH'(i);
            w_win_data = receiver_datas[i*WORD_WIDTH +: WORD_WIDTH];
            w_win_perm = receiver_self_permissions[i*WORD_WIDTH +: WORD_WIDTH];
            w_win_addr = receiver_self_addresses[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   assign w_valid   = (r_count != '0);
   // Full blocks capture even when a dequeue happens in the same cycle.
   assign w_capture = w_found && (r_count != FULL_CNT) && !flush;
   assign w_dequeue = w_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ack <= '0;
      end else begin
         r_ack <= (r_ack | (w_capture ? w_grant : '0)) & receiver_sends;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_capture) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_dequeue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_capture, w_dequeue})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_mem_data[r_wr_ptr] <= w_win_data;
         r_mem_bus[r_wr_ptr]  <= w_win_idx;
         r_mem_perm[r_wr_ptr] <= w_win_perm;
         r_mem_addr[r_wr_ptr] <= w_win_addr;
      end
   end

   assign receiver_send_acks = r_ack;
   assign out_valid          = w_valid;
   assign out_count          = r_count;
   assign out_data           = w_valid ? r_mem_data[r_rd_ptr] : '0;
   assign out_bus            = w_valid ? r_mem_bus[r_rd_ptr]  : '0;
   assign out_permission     = w_valid ? r_mem_perm[r_rd_ptr] : '0;
   assign out_address        = w_valid ? r_mem_addr[r_rd_ptr] : '0;

endmodule

// File: tb/tb_uarc_send_receiver.sv
// Directed bench for uarc_send_receiver with five buses and a four-entry queue.
module tb_uarc_send_receiver;

   localparam int NB = 5;
   localparam int WW = 32;

   logic             clk;
   logic             reset;
   logic [NB-1:0]    bus_enables;
   logic             flush;
   logic [NB-1:0]    receiver_sends;
   logic [NB-1:0]    receiver_send_acks;
   logic [NB*WW-1:0] receiver_datas;
   logic [NB*WW-1:0] receiver_self_permissions;
   logic [NB*WW-1:0] receiver_self_addresses;
   logic             out_valid;
   logic             out_ready;
   logic [WW-1:0]    out_data;
   logic [WW-1:0]    out_bus;
   logic [WW-1:0]    out_permission;
   logic [WW-1:0]    out_address;
   logic [2:0]       out_count;

   int checks = 0;
   int errors = 0;

   uarc_send_receiver #(.WORD_MAG(5), .TOTAL_BUSES(NB), .FIFO_DEPTH_MAG(2)) dut (
      .clk(clk), .reset(reset), .bus_enables(bus_enables), .flush(flush),
      .receiver_sends(receiver_sends), .receiver_send_acks(receiver_send_acks),
      .receiver_datas(receiver_datas),
      .receiver_self_permissions(receiver_self_permissions),
      .receiver_self_addresses(receiver_self_addresses),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_bus(out_bus), .out_permission(out_permission),
      .out_address(out_address), .out_count(out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are observed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      for (int i = 0; i < NB; i++) begin
         receiver_datas[i*WW +: WW]            = 32'hA000_0000 + i;
         receiver_self_permissions[i*WW +: WW] = 32'h0000_0100 + i;
         receiver_self_addresses[i*WW +: WW]   = 32'h0000_0200 + i;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bus_enables = '1; flush = 1'b0; out_ready = 1'b0;
      receiver_sends = '1; set_defaults();
      tick(); tick();
      checks++; if (receiver_send_acks !== 5'b00000) begin errors++; $display("FAIL rst_ack got %b exp %b", receiver_send_acks, 5'b00000); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", out_count); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
      reset = 1'b1;
      tick();
      checks++; if (receiver_send_acks !== 5'b00001) begin errors++; $display("FAIL rst_rel_ack got %b exp %b", receiver_send_acks, 5'b00001); end
      checks++; if (out_valid !== 1'b1 || out_bus !== 32'd0) begin errors++; $display("FAIL rst_rel_head got v=%b bus=%0d exp v=1 bus=0", out_valid, out_bus); end
      checks++; if (out_data !== 32'hA000_0000) begin errors++; $display("FAIL rst_rel_data got %h exp a0000000", out_data); end
      receiver_sends = '0; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (receiver_send_acks !== 5'b00000 || out_count !== 3'd0) begin errors++; $display("FAIL rst_clean got ack=%b cnt=%0d exp ack=00000 cnt=0", receiver_send_acks, out_count); end
   endtask

   task automatic test_single();
      receiver_datas[2*WW +: WW] = 32'hDEAD_BEEF;
      receiver_sends = 5'b00100;
      tick();
      checks++; if (receiver_send_acks !== 5'b00100) begin errors++; $display("FAIL single_ack got %b exp 00100", receiver_send_acks); end
      checks++; if (out_valid !== 1'b1 || out_bus !== 32'd2) begin errors++; $display("FAIL single_head got v=%b bus=%0d exp v=1 bus=2", out_valid, out_bus); end
      checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", out_data); end
      checks++; if (out_permission !== 32'h102 || out_address !== 32'h202) begin errors++; $display("FAIL single_perm_addr got %h/%h exp 102/202", out_permission, out_address); end
      tick();
      checks++; if (receiver_send_acks !== 5'b00100 || out_count !== 3'd1) begin errors++; $display("FAIL single_hold got ack=%b cnt=%0d exp ack=00100 cnt=1", receiver_send_acks, out_count); end
      receiver_sends = '0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (receiver_send_acks !== 5'b00000) begin errors++; $display("FAIL single_release got %b exp 00000", receiver_send_acks); end
      checks++; if (out_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got cnt=%0d v=%b exp 0/0", out_count, out_valid); end
      set_defaults();
   endtask

   task automatic test_contention();
      receiver_sends = 5'b01010;
      tick();
      checks++; if (receiver_send_acks !== 5'b00010) begin errors++; $display("FAIL cont_first got %b exp 00010", receiver_send_acks); end
      tick();
      checks++; if (receiver_send_acks !== 5'b01010 || out_count !== 3'd2) begin errors++; $display("FAIL cont_second got ack=%b cnt=%0d exp 01010/2", receiver_send_acks, out_count); end
      checks++; if (out_bus !== 32'd1) begin errors++; $display("FAIL cont_order1 got %0d exp 1", out_bus); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_bus !== 32'd3 || out_count !== 3'd1) begin errors++; $display("FAIL cont_order2 got bus=%0d cnt=%0d exp 3/1", out_bus, out_count); end
      checks++; if (out_data !== 32'hA000_0003) begin errors++; $display("FAIL cont_data got %h exp a0000003", out_data); end
      receiver_sends = '0;
      tick();
      out_ready = 1'b0;
      checks++; if (receiver_send_acks !== 5'b00000 || out_count !== 3'd0) begin errors++; $display("FAIL cont_end got ack=%b cnt=%0d exp 00000/0", receiver_send_acks, out_count); end
   endtask

   task automatic test_full();
      receiver_sends = 5'b11111;
      for (int k = 0; k < 4; k++) tick();
      checks++; if (receiver_send_acks !== 5'b01111 || out_count !== 3'd4) begin errors++; $display("FAIL full_fill got ack=%b cnt=%0d exp 01111/4", receiver_send_acks, out_count); end
      tick();
      checks++; if (receiver_send_acks !== 5'b01111 || out_count !== 3'd4) begin errors++; $display("FAIL full_block got ack=%b cnt=%0d exp 01111/4", receiver_send_acks, out_count); end
      checks++; if (out_bus !== 32'd0) begin errors++; $display("FAIL full_head got %0d exp 0", out_bus); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (receiver_send_acks !== 5'b01111 || out_count !== 3'd3) begin errors++; $display("FAIL full_nobypass got ack=%b cnt=%0d exp 01111/3", receiver_send_acks, out_count); end
      tick();
      checks++; if (receiver_send_acks !== 5'b11111 || out_count !== 3'd4) begin errors++; $display("FAIL full_fifth got ack=%b cnt=%0d exp 11111/4", receiver_send_acks, out_count); end
      receiver_sends = '0; out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         checks++; if (out_bus !== 32'(k) || out_count !== 3'(5 - k)) begin errors++; $display("FAIL full_drain got bus=%0d cnt=%0d exp %0d/%0d", out_bus, out_count, k, 5 - k); end
      end
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || receiver_send_acks !== 5'b00000) begin errors++; $display("FAIL full_empty got v=%b d=%h ack=%b exp 0/0/00000", out_valid, out_data, receiver_send_acks); end
   endtask

   task automatic test_mask_flush();
      bus_enables = 5'b11110; receiver_sends = 5'b00001;
      tick(); tick();
      checks++; if (receiver_send_acks !== 5'b00000 || out_count !== 3'd0) begin errors++; $display("FAIL mask got ack=%b cnt=%0d exp 00000/0", receiver_send_acks, out_count); end
      bus_enables = '1; receiver_sends = 5'b01110;
      tick(); tick(); tick();
      checks++; if (receiver_send_acks !== 5'b01110 || out_count !== 3'd3) begin errors++; $display("FAIL mask_fill got ack=%b cnt=%0d exp 01110/3", receiver_send_acks, out_count); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (out_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cnt got cnt=%0d v=%b exp 0/0", out_count, out_valid); end
      checks++; if (receiver_send_acks !== 5'b01110) begin errors++; $display("FAIL flush_ack got %b exp 01110", receiver_send_acks); end
      tick();
      checks++; if (out_count !== 3'd0 || receiver_send_acks !== 5'b01110) begin errors++; $display("FAIL flush_norecap got cnt=%0d ack=%b exp 0/01110", out_count, receiver_send_acks); end
      receiver_sends = '0;
      tick();
      checks++; if (receiver_send_acks !== 5'b00000) begin errors++; $display("FAIL flush_release got %b exp 00000", receiver_send_acks); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         receiver_sends = '0;
         receiver_sends[k % NB] = 1'b1;
         receiver_datas[(k % NB)*WW +: WW] = 32'h5000_0000 + k;
         tick();
         checks++; if (out_count !== 3'd1 || out_bus !== 32'(k % NB)) begin errors++; $display("FAIL stream_%0d got cnt=%0d bus=%0d exp 1/%0d", k, out_count, out_bus, k % NB); end
         checks++; if (out_data !== 32'h5000_0000 + k) begin errors++; $display("FAIL stream_data_%0d got %h exp %h", k, out_data, 32'h5000_0000 + k); end
      end
      receiver_sends = '0;
      tick();
      out_ready = 1'b0;
      checks++; if (out_count !== 3'd0 || receiver_send_acks !== 5'b00000) begin errors++; $display("FAIL stream_end got cnt=%0d ack=%b exp 0/00000", out_count, receiver_send_acks); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_full();
      test_mask_flush();
      test_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
